// File: rtl/arm_code_emitter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : jit_emit_pkg
// Description : Shared state encoding and template-table constants for the
//               ARM code emitter.
// Revision    : 1.0 - initial release
//==============================================================================
package jit_emit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } emit_state_t;

  localparam logic [6:0]  IDX_END      = 7'h00;
  localparam logic [6:0]  IDX_BL       = 7'h2C;
  localparam logic [31:0] ROM_UNMAPPED = 32'hFFFF_FFFF;
  localparam logic [31:0] BL_KEEP_MASK = 32'hFF00_0000;
  localparam int          BL_OFF_W     = 24;

endpackage : jit_emit_pkg
`default_nettype wire

// File: rtl/arm_code_emitter_if.sv
`default_nettype none
//==============================================================================
// Module      : arm_code_emitter_if
// Description : Control, index stream, template ROM and code-buffer signals.
// Revision    : 1.0 - initial release
//==============================================================================
interface arm_code_emitter_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              idx_valid;
  logic              idx_ready;
  logic [6:0]        idx;
  logic [ADDR_W-1:0] idx_target;
  logic [6:0]        rom_addr;
  logic [31:0]       rom_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              err;

  // Translator / ROM / buffer side
  modport master (
    output start, base_addr, idx_valid, idx, idx_target, rom_data, mem_ready,
    input  idx_ready, rom_addr, mem_we, mem_addr, mem_wdata, busy, done,
           word_count, err
  );

  // Emitter side
  modport slave (
    input  start, base_addr, idx_valid, idx, idx_target, rom_data, mem_ready,
    output idx_ready, rom_addr, mem_we, mem_addr, mem_wdata, busy, done,
           word_count, err
  );
endinterface : arm_code_emitter_if
`default_nettype wire

// File: rtl/arm_code_emitter_bl_patch.sv
`default_nettype none
//==============================================================================
// Module      : arm_bl_patch
// Description : Rewrites the 24-bit BL offset as target - (wptr + 2).
// Revision    : 1.0 - initial release
//==============================================================================
module arm_bl_patch
  import jit_emit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  wire logic [31:0]       i_word,
  input  wire logic [ADDR_W-1:0] i_wptr,
  input  wire logic [ADDR_W-1:0] i_target,
  output logic      [31:0]       o_word
);

  logic signed [ADDR_W:0]     w_diff;
  logic        [BL_OFF_W-1:0] w_off;

  // ARM PC reads two words ahead of the branch itself
  assign w_diff = signed'({1'b0, i_target} - ({1'b0, i_wptr} + (ADDR_W+1)'(2)));
  assign w_off  = BL_OFF_W'(w_diff);
  assign o_word = (i_word & BL_KEEP_MASK) | {8'h00, w_off};

endmodule : arm_bl_patch
`default_nettype wire

// File: rtl/arm_code_emitter.sv
`default_nettype none
//==============================================================================
// Module      : arm_code_emitter
// Description : Streams ARM templates from the ROM into the JIT code buffer.
// Revision    : 1.0 - initial release
//==============================================================================
module arm_code_emitter
  import jit_emit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input wire logic          clk,
  input wire logic          rst_n,
  arm_code_emitter_if.slave io_emit
);

  emit_state_t       r_state;
  emit_state_t       w_next;

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [6:0]        r_rom_addr;
  logic [31:0]       r_mem_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_full;

  logic [31:0]       w_patched;
  logic [31:0]       w_wdata;
  logic              w_drop;
  logic              w_idx_ready;
  logic              w_mem_we;
  logic              w_done;
  logic              w_busy;

  arm_bl_patch #(
    .ADDR_W (ADDR_W)
  ) u_bl_patch (
    .i_word   (io_emit.rom_data),
    .i_wptr   (r_wptr),
    .i_target (r_target),
    .o_word   (w_patched)
  );

  assign w_wdata = (r_rom_addr == IDX_BL) ? w_patched : io_emit.rom_data;
  assign w_drop  = (io_emit.rom_data == ROM_UNMAPPED) | r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once
  always_comb begin
    w_next      = r_state;
    w_idx_ready = 1'b0;
    w_mem_we    = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (io_emit.start) begin
          w_next = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        w_idx_ready = 1'b1;
        if (io_emit.idx_valid) begin
          w_next = (io_emit.idx == IDX_END) ? ST_DONE : ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        w_next = w_drop ? ST_ACCEPT : ST_WRITE;
      end
      ST_WRITE: begin
        w_mem_we = 1'b1;
        if (io_emit.mem_ready) begin
          w_next = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_target    <= '0;
      r_rom_addr  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_emit.start) begin
            r_wptr  <= io_emit.base_addr;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (io_emit.idx_valid) begin
            r_target <= io_emit.idx_target;
            if (io_emit.idx != IDX_END) begin
              r_rom_addr <= io_emit.idx;
            end
          end
        end
        ST_LOOKUP: begin
          if (w_drop) begin
            r_err <= 1'b1;
          end else begin
            r_mem_addr  <= r_wptr;
            r_mem_wdata <= w_wdata;
          end
        end
        ST_WRITE: begin
          if (io_emit.mem_ready) begin
            r_count <= r_count + (ADDR_W+1)'(1);
            // Top word written: latch full instead of wrapping the pointer
            if (&r_wptr) begin
              r_full <= 1'b1;
            end else begin
              r_wptr <= r_wptr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_emit.idx_ready  = w_idx_ready;
  assign io_emit.rom_addr   = r_rom_addr;
  assign io_emit.mem_we     = w_mem_we;
  assign io_emit.mem_addr   = r_mem_addr;
  assign io_emit.mem_wdata  = r_mem_wdata;
  assign io_emit.busy       = w_busy;
  assign io_emit.done       = w_done;
  assign io_emit.word_count = r_count;
  assign io_emit.err        = r_err;

endmodule : arm_code_emitter
`default_nettype wire
